// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer plot engine.
// Command word layout and the framebuffer geometry live here.
package fb_pkg;

  localparam int H_PIXELS      = 640;
  localparam int V_PIXELS      = 480;
  localparam int WORDS_PER_ROW = 20;
  localparam int FB_WORDS      = 9600;

  localparam int CMD_W   = 22;
  localparam int X_LSB   = 0;
  localparam int X_W     = 10;
  localparam int Y_LSB   = 10;
  localparam int Y_W     = 9;
  localparam int OP_LSB  = 19;
  localparam int VAL_BIT = 21;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_SET  = 2'b01,
    OP_TGL  = 2'b10,
    OP_FILL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MOD,
    WR,
    FILL
  } state_t;

  typedef struct packed {
    logic           val;
    op_t            op;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } cmd_t;

  // y*20 as (y<<4)+(y<<2), plus the word column x[9:5]
  function automatic logic [14:0] word_addr(
    input logic [Y_W-1:0] y,
    input logic [X_W-1:0] x
  );
    logic [14:0] yy;
    yy = {6'd0, y};
    return (yy << 4) + (yy << 2) + {10'd0, x[9:5]};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with fall-through head and level count.
// A push while full is accepted when a pop happens in the same cycle.
module cmd_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 22,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk50) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_plot_engine.sv
// Command-driven pixel writer on framebuffer RAM port B.
// Pixel ops are read-modify-write; fill bursts one word per cycle.
module fb_plot_engine
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [14:0] fb_address,
  output logic [31:0] fb_data,
  output logic        fb_wren,
  input  logic [31:0] fb_q,
  output logic        busy
);

  localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [14:0] FB_LAST = 15'(FB_WORDS - 1);

  state_t      state;
  state_t      nxt;
  cmd_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [LW-1:0] level;
  logic        push;
  logic        pop;
  logic        st_wr;
  logic        rd_en;
  logic        drop;
  logic        head_ok;
  logic        range_hit;
  logic        ovf;
  logic        range_err;
  op_t         cur_op;
  logic [4:0]  cur_bit;
  logic [31:0] mask;
  logic [31:0] modified;
  logic [14:0] addr_d;
  logic [31:0] data_d;
  logic        wren_d;
  logic [31:0] status;
  logic        unused_wd;

  assign push  = chipselect && write && !address;
  assign st_wr = chipselect && write && address;
  assign rd_en = chipselect && read;
  assign drop  = push && fifo_full && !pop;
  assign unused_wd = ^writedata[31:CMD_W];

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (writedata[CMD_W-1:0]),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign head_ok = (head.x < 10'(H_PIXELS))
                && (head.y < 9'(V_PIXELS));
  assign busy = !fifo_empty || (state != IDLE);

  assign mask = 32'd1 << cur_bit;
  always_comb begin
    modified = fb_q ^ mask;
    unique case (cur_op)
      OP_CLR:  modified = fb_q & ~mask;
      OP_SET:  modified = fb_q | mask;
      default: modified = fb_q ^ mask;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head.op == OP_FILL) nxt = FILL;
          else if (head_ok)       nxt = RD;
        end
      end
      RD:   nxt = MOD;
      MOD:  nxt = WR;
      WR:   nxt = IDLE;
      FILL: if (fb_address == FB_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // next values of the registered RAM port-B outputs
  always_comb begin
    pop       = 1'b0;
    range_hit = 1'b0;
    addr_d    = fb_address;
    data_d    = fb_data;
    wren_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.op == OP_FILL) begin
            addr_d = '0;
            data_d = {32{head.val}};
            wren_d = 1'b1;
          end else if (head_ok) begin
            addr_d = word_addr(head.y, head.x);
          end else begin
            range_hit = 1'b1;
          end
        end
      end
      MOD: begin
        data_d = modified;
        wren_d = 1'b1;
      end
      FILL: begin
        if (fb_address != FB_LAST) begin
          addr_d = fb_address + 15'(1);
          wren_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      fb_address <= '0;
      fb_data    <= '0;
      fb_wren    <= 1'b0;
      cur_op     <= OP_CLR;
      cur_bit    <= '0;
    end else begin
      fb_address <= addr_d;
      fb_data    <= data_d;
      fb_wren    <= wren_d;
      if (pop) begin
        cur_op  <= head.op;
        cur_bit <= head.x[4:0];
      end
    end
  end

  assign status = {24'd0, 5'(level), range_err, ovf, busy};

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ovf       <= 1'b0;
      range_err <= 1'b0;
      readdata  <= '0;
    end else begin
      if (drop)                       ovf <= 1'b1;
      else if (st_wr && writedata[1]) ovf <= 1'b0;
      if (range_hit)                  range_err <= 1'b1;
      else if (st_wr && writedata[2]) range_err <= 1'b0;
      if (rd_en) readdata <= address ? status : 32'd0;
    end
  end

endmodule

// File: tb/tb_fb_plot_engine.sv
// Self-checking bench for fb_plot_engine: RAM model on port B plus
// a command-level reference model of framebuffer contents and writes.
module tb_fb_plot_engine;

  localparam int FB_WORDS = 9600;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic        address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [14:0] fb_address;
  logic [31:0] fb_data;
  logic        fb_wren;
  logic [31:0] fb_q;
  logic        busy;

  fb_plot_engine #(.FIFO_DEPTH(16)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .fb_address (fb_address),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .fb_q       (fb_q),
    .busy       (busy)
  );

  always #10 clk50 = ~clk50;

  // port-B RAM, with a bench-side preset path
  logic [31:0] ram [FB_WORDS];
  logic        pre_en = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk50) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (fb_wren && int'(fb_address) < FB_WORDS)
      ram[fb_address] <= fb_data;
    fb_q <= ram[int'(fb_address) < FB_WORDS ? fb_address : 15'd0];
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] ref_mem [FB_WORDS];
  bit          ref_range = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          last_addr = -1;
  logic [31:0] last_data = '0;
  logic [31:0] prev_data = '0;

  task automatic model_cmd(input logic [31:0] c);
    int x, y, op, w, b;
    logic [31:0] nw;
    x  = int'(c[9:0]);
    y  = int'(c[18:10]);
    op = int'(c[20:19]);
    if (op == 3) begin
      for (int i = 0; i < FB_WORDS; i++) begin
        ref_mem[i] = {32{c[21]}};
        exp_q.push_back('{i, {32{c[21]}}});
      end
    end else if (x >= 640 || y >= 480) begin
      ref_range = 1'b1;
    end else begin
      w  = y * 20 + x / 32;
      b  = x % 32;
      nw = ref_mem[w];
      case (op)
        0:       nw[b] = 1'b0;
        1:       nw[b] = 1'b1;
        default: nw[b] = ~nw[b];
      endcase
      ref_mem[w] = nw;
      exp_q.push_back('{w, nw});
    end
  endtask

  always @(negedge clk50) begin : compare
    wr_t e;
    if (reset) begin
      checks++;
      if (fb_wren) begin
        errors++;
        $display("FAIL wren_in_reset: fb_wren=%0b, required 0", fb_wren);
      end
    end else if (fb_wren) begin
      checks++;
      wr_count++;
      prev_data = last_data;
      last_addr = int'(fb_address);
      last_data = fb_data;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write",
                 fb_address, fb_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(fb_address) != e.addr || fb_data != e.data) begin
          errors++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   fb_address, fb_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] cmd(input int op, input int x,
                                      input int y, input bit v);
    return {10'd0, v, 2'(op), 9'(y), 10'(x)};
  endfunction

  function automatic logic [31:0] st(input bit b, input bit o,
                                     input bit r, input int lvl);
    return {24'd0, 5'(lvl), r, o, b};
  endfunction

  task automatic push_cmd(input logic [31:0] c, input bit accepted);
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = c;
    @(posedge clk50); #1;
    chipselect = 1'b0; write = 1'b0;
    if (accepted) model_cmd(c);
  endtask

  task automatic reg_write(input logic [31:0] d);
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = 1'b1; writedata = d;
    @(posedge clk50); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic a, output logic [31:0] v);
    @(negedge clk50);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk50); #1;
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk50); #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic set_ram(input int a, input logic [31:0] d);
    @(negedge clk50);
    pre_en = 1'b1; pre_addr = 15'(a); pre_data = d;
    @(posedge clk50); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  initial begin : stim
    logic [31:0] v;
    logic [31:0] c;
    int n, w0, k;

    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 1'b0; writedata = '0;
    #5 reset = 1'b1;
    @(posedge clk50); #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_fb_address", 32'(fb_address), 32'd0);
    check("rst_fb_data", fb_data, 32'd0);
    check("rst_fb_wren", 32'(fb_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < FB_WORDS; i++) set_ram(i, $urandom);
    @(negedge clk50) reset = 1'b0;

    // set pixel (33,2) on a cleared word
    set_ram(41, 32'h0);
    w0 = wr_count;
    push_cmd(cmd(1, 33, 2, 1'b0), 1'b1);
    wait_idle(50, n);
    check("set_latency", n, 4);
    check("set_writes", wr_count - w0, 1);
    check("set_addr", last_addr, 41);
    check("set_data", last_data, 32'h0000_0002);
    reg_read(1'b1, v);
    check("set_status", v, st(0, 0, 0, 0));

    // back-to-back toggles of the last pixel
    set_ram(9599, 32'hFFFF_FFFF);
    push_cmd(cmd(2, 639, 479, 1'b0), 1'b1);
    push_cmd(cmd(2, 639, 479, 1'b0), 1'b1);
    wait_idle(50, n);
    check("tgl2_latency", n, 7);
    check("tgl_first_data", prev_data, 32'h7FFF_FFFF);
    check("tgl_addr", last_addr, 9599);
    check("tgl_second_data", last_data, 32'hFFFF_FFFF);

    // out-of-range pixel, then the origin pixel
    set_ram(0, 32'h0);
    w0 = wr_count;
    push_cmd(cmd(1, 640, 0, 1'b0), 1'b1);
    wait_idle(50, n);
    check("range_latency", n, 1);
    check("range_no_write", wr_count - w0, 0);
    reg_read(1'b1, v);
    check("range_status", v, st(0, 0, 1, 0));
    push_cmd(cmd(1, 0, 0, 1'b0), 1'b1);
    wait_idle(50, n);
    check("origin_addr", last_addr, 0);
    check("origin_data", last_data, 32'h0000_0001);
    reg_write(32'h4);
    ref_range = 1'b0;
    reg_read(1'b1, v);
    check("range_clear", v, st(0, 0, 0, 0));

    // fill white
    w0 = wr_count;
    push_cmd(cmd(3, 0, 0, 1'b1), 1'b1);
    wait_idle(FB_WORDS + 100, n);
    check("fill_latency", n, FB_WORDS + 1);
    check("fill_writes", wr_count - w0, FB_WORDS);
    check("fill_last_addr", last_addr, FB_WORDS - 1);
    check("fill_last_data", last_data, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk50);
    check("fill_queue_empty", exp_q.size(), 0);

    // overflow while a fill runs
    push_cmd(cmd(3, 0, 0, 1'b0), 1'b1);
    repeat (2) @(posedge clk50);
    for (int i = 0; i < 17; i++) begin
      c = cmd($urandom_range(0, 2), $urandom_range(0, 639),
              $urandom_range(0, 479), 1'b0);
      push_cmd(c, i < 16);
    end
    reg_read(1'b1, v);
    check("ovf_status", v, st(1, 1, 0, 16));
    reg_write(32'h2);
    reg_read(1'b1, v);
    check("ovf_clear", v, st(1, 0, 0, 16));
    reg_read(1'b0, v);
    check("cmd_read_zero", v, 32'd0);
    wait_idle(FB_WORDS + 200, n);
    check("ovf_queue_empty", exp_q.size(), 0);

    // randomized bursts of pixel ops
    for (int r = 0; r < 25; r++) begin
      k = $urandom_range(1, 8);
      for (int i = 0; i < k; i++) begin
        c = $urandom;
        c[9:0]   = 10'($urandom_range(0, 700));
        c[18:10] = 9'($urandom_range(0, 511));
        c[20:19] = 2'($urandom_range(0, 2));
        push_cmd(c, 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk50);
      end
      wait_idle(80, n);
      reg_read(1'b1, v);
      check("burst_status", v, st(0, 0, ref_range, 0));
      check("burst_queue_empty", exp_q.size(), 0);
      if (ref_range) begin
        reg_write(32'h4);
        ref_range = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, FB_WORDS - 1);
      check("ram_vs_model", ram[k], ref_mem[k]);
    end

    // reset in the middle of a fill
    push_cmd(cmd(3, 0, 0, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) push_cmd(cmd(1, 7, 7, 1'b0), 1'b0);
    n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (!(fb_wren && fb_address == 15'd100) && n < 500);
    check("fill_reached_100", 32'(fb_address), 32'd100);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wren", 32'(fb_wren), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk50);
    @(negedge clk50) reset = 1'b0;
    reg_read(1'b1, v);
    check("rst_mid_status", v, 32'd0);
    push_cmd(cmd(1, 5, 0, 1'b0), 1'b1);
    wait_idle(50, n);
    check("post_rst_addr", last_addr, 0);
    check("post_rst_data", last_data, 32'h0000_0020);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
